// File: rtl/carrier_update_sched_if.sv
// Register-side and generator-side bundle for carrier_update_sched.
// master : register interface / testbench (drives writes, commands, carrier feedback)
// slave  : carrier_update_sched (drives the active configuration and status)
// count_mode encoding: 0 COUNT_UP, 1 COUNT_DOWN, 2 COUNT_UPDOWN.
// carr_onoff encoding: 0 CARR_OFF, 1 CARR_ON.
interface carrier_update_sched_if #(
  parameter int W = 16
);
  logic         wr_stb;
  logic [W-1:0] wr_period;
  logic [W-1:0] wr_init;
  logic [1:0]   wr_mode;
  logic [1:0]   upd_sel;
  logic         start_req;
  logic         stop_req;
  logic         stop_sync;
  logic [W-1:0] carrier_in;
  logic [W-1:0] period_o;
  logic [W-1:0] init_carr_o;
  logic [1:0]   count_mode_o;
  logic         carr_onoff_o;
  logic         pending_o;
  logic         upd_done_o;
  logic         sync_o;
  logic         busy_o;

  modport master (
    output wr_stb, wr_period, wr_init, wr_mode, upd_sel,
           start_req, stop_req, stop_sync, carrier_in,
    input  period_o, init_carr_o, count_mode_o, carr_onoff_o,
           pending_o, upd_done_o, sync_o, busy_o
  );

  modport slave (
    input  wr_stb, wr_period, wr_init, wr_mode, upd_sel,
           start_req, stop_req, stop_sync, carrier_in,
    output period_o, init_carr_o, count_mode_o, carr_onoff_o,
           pending_o, upd_done_o, sync_o, busy_o
  );
endinterface

// File: rtl/carrier_update_sched.sv
// Configuration sequencer for one 16-bit carrier generator.
// Shadow copies of period / init_carr / count_mode are written at any time and
// committed to the active outputs only at the boundary chosen by upd_sel, so the
// generator never sees a torn or mid-ramp change. Also sequences carrier
// start/stop and emits a sync pulse on every carrier zero while running.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : carrier_update_sched_if.slave
//     in : wr_stb, wr_period, wr_init, wr_mode, upd_sel, start_req, stop_req,
//          stop_sync, carrier_in
//     out: period_o, init_carr_o, count_mode_o, carr_onoff_o, pending_o,
//          upd_done_o, sync_o, busy_o
module carrier_update_sched #(
  parameter int W = 16
) (
  input logic                   clk,
  input logic                   reset,
  carrier_update_sched_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

  localparam logic [1:0] COUNT_UP = 2'd0;
  localparam logic       CARR_OFF = 1'b0;
  localparam logic       CARR_ON  = 1'b1;

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic [W-1:0] r_carrier_prev;
  logic [W-1:0] r_period;
  logic [W-1:0] r_init;
  logic [1:0]   r_mode;
  logic [W-1:0] r_sh_period;
  logic [W-1:0] r_sh_init;
  logic [1:0]   r_sh_mode;
  logic         r_pending;
  logic         r_upd_done;
  logic         r_sync;
  logic         w_zero_ev;
  logic         w_per_ev;
  logic         w_sel_hit;
  logic         w_commit;
  logic         w_carr_on;
  logic         w_busy;

  // Boundary events, edge-qualified so a two-cycle dwell at an extremum
  // (up/down counting) yields a single event.
  always_comb begin
    w_zero_ev = (bus.carrier_in == {W{1'b0}}) && (r_carrier_prev != {W{1'b0}});
    w_per_ev  = (bus.carrier_in == r_period) && (r_carrier_prev != r_period) &&
                (r_period != {W{1'b0}});
  end

  // Commit decision: always immediate while idle, otherwise at the selected boundary.
  always_comb begin
    w_sel_hit = 1'b0;
    case (bus.upd_sel)
      2'd0:    w_sel_hit = 1'b1;
      2'd1:    w_sel_hit = w_zero_ev;
      2'd2:    w_sel_hit = w_per_ev;
      2'd3:    w_sel_hit = w_zero_ev | w_per_ev;
      default: w_sel_hit = 1'b0;
    endcase
    w_commit = r_pending & ((r_state == ST_IDLE) | w_sel_hit);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; stop beats a simultaneous start.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_req && !bus.stop_req) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.stop_req) begin
          if (bus.stop_sync) begin
            w_state_nxt = ST_STOPPING;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_STOPPING: begin
        // A zero period never produces a zero event, so leave at once.
        if (w_zero_ev || (r_period == {W{1'b0}})) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_STOPPING;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    w_carr_on = CARR_OFF;
    w_busy    = 1'b0;
    case (r_state)
      ST_RUN, ST_STOPPING: begin
        w_carr_on = CARR_ON;
        w_busy    = 1'b1;
      end
      default: begin
        w_carr_on = CARR_OFF;
        w_busy    = 1'b0;
      end
    endcase
  end

  // Shadow capture, active configuration commit and registered pulses.
  // A write coinciding with a commit is captured after the old shadow is used.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_carrier_prev <= {W{1'b0}};
      r_period       <= {W{1'b0}};
      r_init         <= {W{1'b0}};
      r_mode         <= COUNT_UP;
      r_sh_period    <= {W{1'b0}};
      r_sh_init      <= {W{1'b0}};
      r_sh_mode      <= 2'd0;
      r_pending      <= 1'b0;
      r_upd_done     <= 1'b0;
      r_sync         <= 1'b0;
    end else begin
      r_carrier_prev <= bus.carrier_in;
      if (w_commit) begin
        r_period <= r_sh_period;
        r_init   <= r_sh_init;
        r_mode   <= r_sh_mode;
      end
      if (bus.wr_stb) begin
        r_sh_period <= bus.wr_period;
        r_sh_init   <= bus.wr_init;
        r_sh_mode   <= bus.wr_mode;
      end
      r_pending  <= bus.wr_stb | (r_pending & ~w_commit);
      r_upd_done <= w_commit;
      r_sync     <= w_zero_ev & (r_state == ST_RUN);
    end
  end

  assign bus.period_o     = r_period;
  assign bus.init_carr_o  = r_init;
  assign bus.count_mode_o = r_mode;
  assign bus.carr_onoff_o = w_carr_on;
  assign bus.pending_o    = r_pending;
  assign bus.upd_done_o   = r_upd_done;
  assign bus.sync_o       = r_sync;
  assign bus.busy_o       = w_busy;

endmodule

// File: tb/tb_carrier_update_sched.sv
// Self-checking bench for carrier_update_sched: directed vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_carrier_update_sched;
  localparam int W = 16;
  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, UPDOWN = 2'd2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  carrier_update_sched_if #(.W(W)) bus();
  carrier_update_sched #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (state: 0 idle, 1 run, 2 stopping).
  int         m_state;
  logic [15:0] m_period, m_init, m_sh_period, m_sh_init, m_prev;
  logic [1:0]  m_mode, m_sh_mode;
  logic        m_pending, m_upd, m_sync;

  typedef struct {
    logic        ws;
    logic [15:0] wp;
    logic        st;
    logic        sp;
    logic        ss;
    logic [15:0] c;
    logic [15:0] e_per;
    logic        e_on;
    logic        e_pend;
    logic        e_upd;
    logic        e_sync;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic ws, input logic [15:0] wp, input logic st,
                              input logic sp, input logic ss, input logic [15:0] c,
                              input logic [15:0] ep, input logic eon, input logic epd,
                              input logic eup, input logic esy);
    vec_t v;
    v.ws = ws; v.wp = wp; v.st = st; v.sp = sp; v.ss = ss; v.c = c;
    v.e_per = ep; v.e_on = eon; v.e_pend = epd; v.e_upd = eup; v.e_sync = esy;
    return v;
  endfunction

  function automatic logic [38:0] dut_vec();
    return {bus.period_o, bus.init_carr_o, bus.count_mode_o, bus.carr_onoff_o,
            bus.pending_o, bus.upd_done_o, bus.sync_o, bus.busy_o};
  endfunction

  function automatic logic [38:0] model_vec();
    return {m_period, m_init, m_mode, (m_state != 0), m_pending, m_upd, m_sync,
            (m_state != 0)};
  endfunction

  task automatic check_vec(input string name, input logic [38:0] act, input logic [38:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_period = 16'd0; m_init = 16'd0; m_mode = UP;
    m_sh_period = 16'd0; m_sh_init = 16'd0; m_sh_mode = 2'd0; m_prev = 16'd0;
    m_pending = 1'b0; m_upd = 1'b0; m_sync = 1'b0;
  endtask

  // One clock of the specified behaviour, evaluated from pre-edge values.
  task automatic model_step();
    logic zero_ev, per_ev, hit, commit;
    int   nxt;
    zero_ev = (bus.carrier_in == 16'd0) && (m_prev != 16'd0);
    per_ev  = (bus.carrier_in == m_period) && (m_prev != m_period) && (m_period != 16'd0);
    case (bus.upd_sel)
      2'd0:    hit = 1'b1;
      2'd1:    hit = zero_ev;
      2'd2:    hit = per_ev;
      default: hit = zero_ev || per_ev;
    endcase
    commit = m_pending && (m_state == 0 || hit);
    nxt = m_state;
    if (m_state == 0) begin
      if (bus.start_req && !bus.stop_req) nxt = 1;
    end else if (m_state == 1) begin
      if (bus.stop_req) nxt = bus.stop_sync ? 2 : 0;
    end else begin
      if (zero_ev || m_period == 16'd0) nxt = 0;
    end
    m_sync = zero_ev && (m_state == 1);
    m_upd  = commit;
    if (commit) begin
      m_period = m_sh_period; m_init = m_sh_init; m_mode = m_sh_mode;
    end
    if (bus.wr_stb) begin
      m_sh_period = bus.wr_period; m_sh_init = bus.wr_init; m_sh_mode = bus.wr_mode;
      m_pending = 1'b1;
    end else if (commit) begin
      m_pending = 1'b0;
    end
    m_state = nxt;
    m_prev  = bus.carrier_in;
  endtask

  task automatic drive(input logic ws, input logic [15:0] p, input logic [15:0] ini,
                       input logic [1:0] md, input logic [1:0] sel, input logic st,
                       input logic sp, input logic ss, input logic [15:0] c);
    @(negedge clk);
    bus.wr_stb = ws; bus.wr_period = p; bus.wr_init = ini; bus.wr_mode = md;
    bus.upd_sel = sel; bus.start_req = st; bus.stop_req = sp; bus.stop_sync = ss;
    bus.carrier_in = c;
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    model_step();
    #1;
    check_vec(name, dut_vec(), model_vec());
  endtask

  task automatic cycle(input string name, input logic ws, input logic [15:0] p,
                       input logic [15:0] ini, input logic [1:0] md, input logic [1:0] sel,
                       input logic st, input logic sp, input logic ss, input logic [15:0] c);
    drive(ws, p, ini, md, sel, st, sp, ss, c);
    tick(name);
  endtask

  initial begin
    logic [15:0] q_c[$];
    logic        q_w[$];
    int          n_upd, n_sync;
    logic [15:0] c;
    logic        dir_up;

    // Reset state.
    reset = 1'b1;
    bus.wr_stb = 1'b0; bus.wr_period = 16'd0; bus.wr_init = 16'd0; bus.wr_mode = UP;
    bus.upd_sel = 2'd1; bus.start_req = 1'b0; bus.stop_req = 1'b0; bus.stop_sync = 1'b0;
    bus.carrier_in = 16'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_values", dut_vec(), 39'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: commit in IDLE, zero-aligned update, sync/immediate stop, start/stop clash.
    tbl[0]  = mk(1'b1, 16'd100, 1'b0, 1'b0, 1'b0, 16'd0,   16'd0,   1'b0, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 16'd0,   1'b1, 1'b0, 1'b0, 16'd0,   16'd100, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 16'd1,   16'd100, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 16'd50,  1'b0, 1'b0, 1'b0, 16'd30,  16'd100, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 16'd31,  16'd100, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 16'd100, 16'd100, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 16'd0,   16'd50,  1'b1, 1'b0, 1'b1, 1'b1);
    tbl[7]  = mk(1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 16'd1,   16'd50,  1'b1, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 16'd0,   1'b0, 1'b1, 1'b1, 16'd4,   16'd50,  1'b1, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 16'd5,   16'd50,  1'b1, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 16'd0,   16'd50,  1'b0, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 16'd0,   1'b1, 1'b0, 1'b0, 16'd1,   16'd50,  1'b1, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 16'd0,   1'b0, 1'b1, 1'b0, 16'd2,   16'd50,  1'b0, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, 16'd0,   1'b1, 1'b1, 1'b0, 16'd3,   16'd50,  1'b0, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b0, 16'd0,   1'b0, 1'b1, 1'b0, 16'd3,   16'd50,  1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      cycle("table_model", tbl[i].ws, tbl[i].wp, 16'd0, UP, 2'd1,
            tbl[i].st, tbl[i].sp, tbl[i].ss, tbl[i].c);
      n_tests++;
      if ({bus.period_o, bus.carr_onoff_o, bus.pending_o, bus.upd_done_o, bus.sync_o} !==
          {tbl[i].e_per, tbl[i].e_on, tbl[i].e_pend, tbl[i].e_upd, tbl[i].e_sync}) begin
        n_fail++;
        $display("FAIL table row %0d: got per=%0d on=%b pend=%b upd=%b sync=%b expected per=%0d on=%b pend=%b upd=%b sync=%b",
                 i, bus.period_o, bus.carr_onoff_o, bus.pending_o, bus.upd_done_o, bus.sync_o,
                 tbl[i].e_per, tbl[i].e_on, tbl[i].e_pend, tbl[i].e_upd, tbl[i].e_sync);
      end
    end

    // Up/down, period 10, commit at period: one commit per peak despite the dwell.
    cycle("ud_setup", 1'b1, 16'd10, 16'd0, UPDOWN, 2'd2, 1'b0, 1'b0, 1'b0, 16'd0);
    cycle("ud_start", 1'b0, 16'd0, 16'd0, UP, 2'd2, 1'b1, 1'b0, 1'b0, 16'd0);
    for (int t = 0; t < 3; t++) begin
      for (int v = 1; v <= 10; v++) begin q_c.push_back(16'(v)); q_w.push_back(v == 5); end
      q_c.push_back(16'd10); q_w.push_back(1'b0);
      for (int v = 9; v >= 0; v--) begin q_c.push_back(16'(v)); q_w.push_back(1'b0); end
      q_c.push_back(16'd0); q_w.push_back(1'b0);
    end
    n_upd = 0; n_sync = 0;
    for (int k = 0; k < q_c.size(); k++) begin
      cycle("ud_model", q_w[k], 16'd10, 16'd0, UPDOWN, 2'd2, 1'b0, 1'b0, 1'b0, q_c[k]);
      if (bus.upd_done_o) n_upd++;
      if (bus.sync_o) n_sync++;
    end
    check_int("updown_commits_per_peak", n_upd, 3);
    check_int("updown_sync_per_valley", n_sync, 3);

    // Write in the same cycle as a zero-aligned commit.
    cycle("sim_a", 1'b1, 16'd12, 16'd3, UP, 2'd1, 1'b0, 1'b0, 1'b0, 16'd1);
    cycle("sim_b", 1'b0, 16'd0, 16'd0, UP, 2'd1, 1'b0, 1'b0, 1'b0, 16'd2);
    cycle("sim_c", 1'b1, 16'd14, 16'd7, UP, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0);
    check_int("sim_old_committed", int'(bus.period_o), 12);
    check_int("sim_pending_kept", int'(bus.pending_o), 1);
    check_int("sim_upd_pulse", int'(bus.upd_done_o), 1);
    cycle("sim_d", 1'b0, 16'd0, 16'd0, UP, 2'd1, 1'b0, 1'b0, 1'b0, 16'd1);
    cycle("sim_e", 1'b0, 16'd0, 16'd0, UP, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0);
    check_int("sim_new_committed", int'(bus.period_o), 14);
    check_int("sim_pending_clear", int'(bus.pending_o), 0);

    // Reset asserted mid-STOPPING, then normal restart.
    cycle("stp_req", 1'b0, 16'd0, 16'd0, UP, 2'd1, 1'b0, 1'b1, 1'b1, 16'd4);
    cycle("stp_hold", 1'b0, 16'd0, 16'd0, UP, 2'd1, 1'b0, 1'b0, 1'b0, 16'd5);
    check_int("stopping_still_on", int'(bus.carr_onoff_o), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_vec("async_reset_mid_stopping", dut_vec(), 39'd0);
    model_reset();
    bus.carrier_in = 16'd0; bus.stop_req = 1'b0; bus.stop_sync = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cycle("rst_wr", 1'b1, 16'd20, 16'd5, DOWN, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cycle("rst_start", 1'b0, 16'd0, 16'd0, UP, 2'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    check_int("restart_period", int'(bus.period_o), 20);
    check_int("restart_on", int'(bus.carr_onoff_o), 1);

    // Randomized run against the model, carrier produced by a behavioural generator.
    c = 16'd0; dir_up = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      case (m_mode)
        UP:   c = (c >= m_period) ? 16'd0 : c + 16'd1;
        DOWN: c = (c == 16'd0 || c > m_period) ? m_period : c - 16'd1;
        default: begin
          if (c > m_period) c = m_period;
          else if (dir_up) begin
            if (c >= m_period) dir_up = 1'b0; else c = c + 16'd1;
          end else begin
            if (c == 16'd0) dir_up = 1'b1; else c = c - 16'd1;
          end
        end
      endcase
      if ($urandom_range(0, 31) == 0) c = 16'($urandom_range(0, 15));
      cycle("random_model", ($urandom_range(0, 7) == 0), 16'($urandom_range(0, 12)),
            16'($urandom_range(0, 255)), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 1)), c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/carrier_update_sched.md
Name: carrier_update_sched

Overview:
- Configuration sequencer for one carrier_gen_16bits instance in the pwm8carr datapath.
- Holds shadow copies of period, init_carr and count_mode written by the register interface, and commits them to the active outputs only at a selected carrier boundary. This prevents torn or mid-ramp changes.
- Sequences carrier start and stop (immediate or synchronised to carrier zero) and emits a sync pulse for chaining further carriers.

Parameters:
- W, `PWMCOUNT_WIDTH (16): counter width of period, init_carr and carrier.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_stb  in  1  one-cycle strobe; captures wr_period, wr_init and wr_mode into the shadow registers.
- wr_period  in  W  new period.
- wr_init  in  W  new initial carrier value.
- wr_mode  in  _count_mode  new count mode (COUNT_UP, COUNT_DOWN, COUNT_UPDOWN).
- upd_sel  in  2  commit point: 0 immediate, 1 carrier zero, 2 carrier period, 3 zero or period.
- start_req  in  1  one-cycle start strobe.
- stop_req  in  1  one-cycle stop strobe.
- stop_sync  in  1  1 = stop at the next zero event; 0 = stop immediately.
- carrier_in  in  W  carrier fed back from the generator.
- period_o  out  W  active period to the generator.
- init_carr_o  out  W  active init_carr to the generator.
- count_mode_o  out  _count_mode  active count mode.
- carr_onoff_o  out  _carr_onoff  CARR_ON only in RUN and STOPPING.
- pending_o  out  1  shadow holds uncommitted data.
- upd_done_o  out  1  one-cycle pulse, the cycle after a commit.
- sync_o  out  1  one-cycle pulse on each zero event while in RUN.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset values: period_o 0, init_carr_o 0, count_mode_o COUNT_UP, carr_onoff_o CARR_OFF, pending_o 0, upd_done_o 0, sync_o 0, busy_o 0, state IDLE, carrier_prev 0, all shadow registers 0. Reset asserted mid-operation aborts everything and returns to these values.
- Shadow capture:
  - wr_stb loads the shadow registers and sets pending.
  - A second wr_stb while pending overwrites the shadow; pending stays 1.
- Event detection (carrier_prev registers carrier_in every cycle):
  - zero_ev = (carrier_in == 0) && (carrier_prev != 0).
  - per_ev = (carrier_in == period_o) && (carrier_prev != period_o) && (period_o != 0).
  - Edge qualification yields one event per boundary even when COUNT_UPDOWN dwells two cycles at an extremum.
- Commit condition: pending && (state == IDLE || upd_sel == 0 || (upd_sel == 1 && zero_ev) || (upd_sel == 2 && per_ev) || (upd_sel == 3 && (zero_ev || per_ev))).
- Commit action: active outputs take the shadow values at the next edge, pending clears, and upd_done_o pulses in that same next cycle. Latency is exactly 1 clock from the qualifying cycle.
- Simultaneous wr_stb and commit: the commit uses the old shadow; the new write is captured and pending remains 1.
- FSM:
  - IDLE: carr_onoff_o CARR_OFF. On start_req: commit if pending, then go to RUN.
  - RUN: carr_onoff_o CARR_ON. On stop_req with stop_sync = 0, go to IDLE next cycle. On stop_req with stop_sync = 1, go to STOPPING.
  - STOPPING: carr_onoff_o CARR_ON; commits still allowed. On zero_ev go to IDLE. If period_o == 0, go to IDLE next cycle.
  - start_req in RUN or STOPPING is ignored. stop_req in IDLE is ignored.
  - start_req and stop_req in the same cycle: stop wins; from IDLE, nothing happens.
- sync_o = registered (zero_ev && state == RUN); it pulses one cycle after the zero is seen.
- Wrap-around: carrier_in is only compared, never incremented, so no arithmetic overflow is possible.

Test Plan:
- Reset, then wr_stb(period 100, init 0, UP), then start_req -> the commit happens in IDLE; period_o = 100 and upd_done_o pulses one cycle later; carr_onoff_o = CARR_ON; pending_o = 0.
- In RUN with upd_sel = 1, wr_stb(period 50) at carrier 30 -> period_o stays 100 until carrier wraps 100 -> 0; it becomes 50 one cycle after that zero, with exactly one upd_done_o pulse.
- COUNT_UPDOWN, period 10, upd_sel = 2 -> exactly one commit per peak despite the carrier dwelling 2 cycles at 10; sync_o pulses once per valley.
- stop_req with stop_sync = 1 at carrier 4 counting up to 10 -> STOPPING; carr_onoff_o goes CARR_OFF one cycle after carrier reaches 0. With stop_sync = 0 -> CARR_OFF the next cycle.
- wr_stb in the same cycle as a commit -> the old value is committed, pending_o stays 1, and the new value commits at the next event.
- reset asserted mid-STOPPING -> all outputs return to their reset values asynchronously; a later start_req resumes normal operation.
